// File: rtl/csmulti_product_accumulator_if.sv
// Product-in / batch-sum-out handshake bundle for the carry-save multiplier accumulator.
// The slave modport is the accumulator side; the master modport is the producer/consumer side.
interface csmulti_product_accumulator_if #(
  parameter int bitsize   = 8,
  parameter int ACC_WIDTH = 18
);
  logic [2*bitsize-1:0] prod_i;
  logic                 prod_valid;
  logic                 prod_ready;
  logic [ACC_WIDTH-1:0] acc_o;
  logic                 acc_valid;
  logic                 acc_ready;
  logic                 overflow;
  logic [7:0]           count_o;

  modport master (
    output prod_i, prod_valid, acc_ready,
    input  prod_ready, acc_o, acc_valid, overflow, count_o
  );

  modport slave (
    input  prod_i, prod_valid, acc_ready,
    output prod_ready, acc_o, acc_valid, overflow, count_o
  );
endinterface

// File: rtl/csmulti_product_accumulator.sv
// Sums batches of ACC_COUNT unsigned multiplier products into an ACC_WIDTH accumulator and
// holds each batch sum, with a sticky wrap flag, until the consumer takes it.
module csmulti_product_accumulator #(
  parameter int bitsize   = 8,
  parameter int ACC_COUNT = 4,
  parameter int ACC_WIDTH = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  csmulti_product_accumulator_if.slave bus
);
  localparam int         PW       = 2 * bitsize;
  localparam logic [7:0] LAST_IDX = 8'(ACC_COUNT - 1);

  generate
    if (ACC_WIDTH < PW) begin : g_bad_width
      $error("csmulti_product_accumulator: ACC_WIDTH must be at least 2*bitsize");
    end
    if ((ACC_COUNT < 1) || (ACC_COUNT > 255)) begin : g_bad_count
      $error("csmulti_product_accumulator: ACC_COUNT must be in 1..255");
    end
  endgenerate

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state_p0;
  state_t               state_nxt;
  logic [ACC_WIDTH-1:0] sum_p0;
  logic                 ovf_p0;
  logic [7:0]           count_p0;
  logic [ACC_WIDTH-1:0] acc_p1;
  logic                 ovf_p1;
  logic                 vld_p1;
  logic                 prod_rdy;
  logic                 xfer;
  logic                 last;
  logic [ACC_WIDTH:0]   add_p0;

  // Zero-extends the product and keeps the carry out of the top accumulator bit.
  function automatic logic [ACC_WIDTH:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [PW-1:0]        p);
    return {1'b0, a} + {{(ACC_WIDTH + 1 - PW){1'b0}}, p};
  endfunction

  assign xfer   = bus.prod_valid & prod_rdy;
  assign last   = (count_p0 == LAST_IDX);
  assign add_p0 = acc_add(sum_p0, bus.prod_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_p0 <= ACCUM;
    else     state_p0 <= state_nxt;
  end

  // clear outranks both handshakes, so a pending HOLD result is simply dropped.
  always_comb begin
    state_nxt = state_p0;
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state_p0)
        ACCUM:   if (xfer && last)     state_nxt = HOLD;
        HOLD:    if (bus.acc_ready)    state_nxt = ACCUM;
        default:                       state_nxt = ACCUM;
      endcase
    end
  end

  always_comb begin
    prod_rdy = 1'b0;
    vld_p1   = 1'b0;
    case (state_p0)
      ACCUM:   prod_rdy = 1'b1;
      HOLD:    vld_p1   = 1'b1;
      default: ;
    endcase
  end

  // Stage p0: running sum, sticky wrap and product count for the batch in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_p0   <= '0;
      ovf_p0   <= 1'b0;
      count_p0 <= '0;
    end else if (clear) begin
      sum_p0   <= '0;
      ovf_p0   <= 1'b0;
      count_p0 <= '0;
    end else if (xfer) begin
      if (last) begin
        sum_p0   <= '0;
        ovf_p0   <= 1'b0;
        count_p0 <= '0;
      end else begin
        sum_p0   <= add_p0[ACC_WIDTH-1:0];
        ovf_p0   <= ovf_p0 | add_p0[ACC_WIDTH];
        count_p0 <= count_p0 + 8'd1;
      end
    end
  end

  // Stage p1: completed batch sum; it keeps its value after hand-off until the next batch lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else if (clear) begin
      ovf_p1 <= 1'b0;
    end else if (xfer && last) begin
      acc_p1 <= add_p0[ACC_WIDTH-1:0];
      ovf_p1 <= ovf_p0 | add_p0[ACC_WIDTH];
    end
  end

  assign bus.prod_ready = prod_rdy;
  assign bus.acc_valid  = vld_p1;
  assign bus.acc_o      = acc_p1;
  assign bus.overflow   = ovf_p1;
  assign bus.count_o    = count_p0;
endmodule

// File: tb/tb_csmulti_product_accumulator.sv
// Directed bench for csmulti_product_accumulator: a batch-sum model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_csmulti_product_accumulator;
  localparam int BS = 8;
  localparam int N  = 4;
  localparam int W  = 18;
  localparam int W2 = 17;
  localparam longint MOD = 64'd1 << W;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  csmulti_product_accumulator_if #(.bitsize(BS), .ACC_WIDTH(W))  bus1 ();
  csmulti_product_accumulator_if #(.bitsize(BS), .ACC_WIDTH(W2)) bus2 ();

  csmulti_product_accumulator #(.bitsize(BS), .ACC_COUNT(N), .ACC_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus1.slave)
  );
  csmulti_product_accumulator #(.bitsize(BS), .ACC_COUNT(N), .ACC_WIDTH(W2)) dut17 (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus2.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a batch is the list of accepted products; its result is their plain sum.
  logic   m_hold  = 1'b0;
  longint m_total = 0;
  int     m_cnt   = 0;
  longint m_acc   = 0;
  logic   m_ovf   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold <= 1'b0; m_total <= 0; m_cnt <= 0; m_acc <= 0; m_ovf <= 1'b0;
    end else if (clear) begin
      m_hold <= 1'b0; m_total <= 0; m_cnt <= 0; m_ovf <= 1'b0;
    end else if (m_hold) begin
      if (bus1.acc_ready) m_hold <= 1'b0;
    end else if (bus1.prod_valid) begin
      if (m_cnt + 1 == N) begin
        m_acc   <= (m_total + longint'(bus1.prod_i)) % MOD;
        m_ovf   <= (m_total + longint'(bus1.prod_i)) >= MOD;
        m_hold  <= 1'b1;
        m_total <= 0;
        m_cnt   <= 0;
      end else begin
        m_total <= m_total + longint'(bus1.prod_i);
        m_cnt   <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("model prod_ready", bus1.prod_ready, !m_hold);
    chk("model acc_valid", bus1.acc_valid, m_hold);
    chk("model count_o", bus1.count_o, m_cnt);
    if (m_hold) begin
      chk("model acc_o", bus1.acc_o, m_acc);
      chk("model overflow", bus1.overflow, m_ovf);
    end
  end

  task automatic cyc(input logic v, input logic [15:0] d, input logic r, input logic c);
    bus1.prod_valid = v; bus1.prod_i = d; bus1.acc_ready = r;
    bus2.prod_valid = v; bus2.prod_i = d; bus2.acc_ready = r;
    clear = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int gap_v[7];
    int gap_d[7];
    int gap_c[7];
    gap_v = '{1, 0, 0, 1, 0, 1, 1};
    gap_d = '{10, 0, 0, 20, 0, 30, 40};
    gap_c = '{1, 1, 1, 2, 2, 3, 0};

    bus1.prod_valid = 1'b0; bus1.prod_i = '0; bus1.acc_ready = 1'b1;
    bus2.prod_valid = 1'b0; bus2.prod_i = '0; bus2.acc_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("reset count_o", bus1.count_o, 0);
    chk("reset acc_valid", bus1.acc_valid, 0);
    chk("reset overflow", bus1.overflow, 0);
    chk("reset acc_o", bus1.acc_o, 0);
    chk("reset prod_ready", bus1.prod_ready, 1);
    @(posedge clk); #2;
    rst = 1'b0;

    // Back-to-back batch 3,5,7,9
    cyc(1, 3, 1, 0); cyc(1, 5, 1, 0); cyc(1, 7, 1, 0);
    chk("b2b count before last", bus1.count_o, 3);
    cyc(1, 9, 1, 0);
    chk("b2b acc_valid", bus1.acc_valid, 1);
    chk("b2b acc_o", bus1.acc_o, 24);
    chk("b2b overflow", bus1.overflow, 0);
    chk("b2b prod_ready low", bus1.prod_ready, 0);
    chk("b2b count reset", bus1.count_o, 0);
    cyc(0, 0, 1, 0);
    chk("b2b acc_valid drop", bus1.acc_valid, 0);
    chk("b2b prod_ready back", bus1.prod_ready, 1);

    // Largest 8x8 products; the 17-bit instance wraps
    for (int i = 0; i < 4; i++) cyc(1, 16'd65025, 1, 0);
    chk("max acc_o w18", bus1.acc_o, 260100);
    chk("max overflow w18", bus1.overflow, 0);
    chk("max acc_o w17", bus2.acc_o, 129028);
    chk("max overflow w17", bus2.overflow, 1);
    cyc(0, 0, 1, 0);

    // Back-pressure: result held, offered products ignored
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 100, 0, 0);
      chk("stall acc_o", bus1.acc_o, 4);
      chk("stall prod_ready", bus1.prod_ready, 0);
      chk("stall acc_valid", bus1.acc_valid, 1);
    end
    cyc(1, 100, 1, 0);
    chk("release count_o", bus1.count_o, 0);
    chk("release acc_valid", bus1.acc_valid, 0);
    cyc(1, 100, 1, 0);
    chk("first 100 accepted", bus1.count_o, 1);
    for (int i = 0; i < 3; i++) cyc(1, 100, 1, 0);
    chk("hundreds acc_o", bus1.acc_o, 400);
    cyc(0, 0, 1, 0);

    // Gapped valid
    for (int i = 0; i < 7; i++) begin
      cyc(gap_v[i][0], 16'(gap_d[i]), 1, 0);
      chk("gap count_o", bus1.count_o, gap_c[i]);
    end
    chk("gap acc_valid", bus1.acc_valid, 1);
    chk("gap acc_o", bus1.acc_o, 100);
    cyc(0, 0, 1, 0);

    // clear mid-batch drops the product offered with it
    cyc(1, 6, 1, 0); cyc(1, 6, 1, 0);
    chk("pre-clear count_o", bus1.count_o, 2);
    cyc(1, 50, 1, 1);
    chk("clear count_o", bus1.count_o, 0);
    cyc(1, 1, 1, 0); cyc(1, 2, 1, 0); cyc(1, 3, 1, 0); cyc(1, 4, 1, 0);
    chk("post-clear acc_o", bus1.acc_o, 10);
    chk("post-clear acc_valid", bus1.acc_valid, 1);
    cyc(1, 77, 0, 1);
    chk("clear in hold acc_valid", bus1.acc_valid, 0);
    chk("clear in hold count_o", bus1.count_o, 0);
    cyc(0, 0, 1, 0);
    chk("clear in hold stays idle", bus1.acc_valid, 0);

    // Asynchronous reset mid-batch
    for (int i = 0; i < 4; i++) cyc(1, 16'd65025, 1, 0);
    cyc(0, 0, 1, 0);
    chk("w17 overflow retained", bus2.overflow, 1);
    cyc(1, 2, 1, 0); cyc(1, 2, 1, 0);
    chk("pre-rst count_o", bus1.count_o, 2);
    #1 rst = 1'b1;
    #1;
    chk("async rst count_o", bus1.count_o, 0);
    chk("async rst acc_valid", bus1.acc_valid, 0);
    chk("async rst acc_o", bus1.acc_o, 0);
    chk("async rst overflow w17", bus2.overflow, 0);
    chk("async rst acc_o w17", bus2.acc_o, 0);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 2, 1, 0);
    chk("post-rst acc_o", bus1.acc_o, 8);
    chk("post-rst acc_valid", bus1.acc_valid, 1);
    cyc(0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
